// File: rtl/led_cal_seq_ctrl_pkg.sv
// Shared types and helpers for the multi-channel LED calibration sequencer:
// the FSM state encoding, a one-hot decoder and an integer clamp.
package led_cal_seq_ctrl_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [2:0] {
        IDLE,
        DC_SRCH,
        PGA_SRCH,
        NEXT_CH,
        OPERATION
    } state_t;

    function automatic logic [MAX_CH-1:0] one_hot(input int idx);
        return MAX_CH'(1) << idx;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/led_cal_seq_ctrl_if.sv
// ADC input and analog front-end control bundle of the calibration sequencer.
// The master modport is the controller, the slave modport is the ADC/AFE side.
interface led_cal_seq_ctrl_if #(
    parameter int N_CH  = 2,
    parameter int ADC_W = 8,
    parameter int DC_W  = 7,
    parameter int PGA_W = 4
);
    logic [ADC_W-1:0]      ADC;
    logic                  ADC_Vld;
    logic                  Find_setting;
    logic [N_CH-1:0]       LED_EN;
    logic [DC_W-1:0]       DC_Comp;
    logic [PGA_W-1:0]      PGA_Gain;
    logic                  CLK_Filter;
    logic [N_CH*ADC_W-1:0] ADC_Value;
    logic [N_CH-1:0]       ADC_Value_Vld;
    logic                  Cal_Done;
    logic [N_CH-1:0]       Cal_Fail;

    modport master (
        input  ADC, ADC_Vld, Find_setting,
        output LED_EN, DC_Comp, PGA_Gain, CLK_Filter, ADC_Value, ADC_Value_Vld, Cal_Done, Cal_Fail
    );

    modport slave (
        output ADC, ADC_Vld, Find_setting,
        input  LED_EN, DC_Comp, PGA_Gain, CLK_Filter, ADC_Value, ADC_Value_Vld, Cal_Done, Cal_Fail
    );
endinterface

// File: rtl/led_cal_seq_ctrl_win_minmax.sv
// Measurement window: counts valid ADC samples, tracks min/max and clipping, and
// raises close on the WIN-th sample with midpoint/clip already including that sample.
module led_cal_seq_ctrl_win_minmax #(
    parameter int ADC_W   = 8,
    parameter int WIN     = 16,
    parameter int CLIP_LO = 10,
    parameter int CLIP_HI = 245
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [ADC_W-1:0] sample,
    input  logic             vld,
    output logic             close,
    output logic             clip,
    output logic [ADC_W:0]   mid
);
    localparam int CNT_W = $clog2(WIN);
    localparam int MID_W = ADC_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [ADC_W-1:0] min_q, max_q, min_d, max_d;
    logic             clip_q, sample_clip;

    always_comb begin
        sample_clip = (sample < ADC_W'(CLIP_LO)) || (sample > ADC_W'(CLIP_HI));
        min_d       = (sample < min_q) ? sample : min_q;
        max_d       = (sample > max_q) ? sample : max_q;
        close       = vld && (cnt == CNT_W'(WIN - 1));
        clip        = clip_q || sample_clip;
        mid         = MID_W'(({1'b0, max_d} + {1'b0, min_d}) >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst || clear || close) begin
            cnt    <= '0;
            min_q  <= '1;
            max_q  <= '0;
            clip_q <= 1'b0;
        end else if (vld) begin
            cnt    <= cnt + 1'b1;
            min_q  <= min_d;
            max_q  <= max_d;
            clip_q <= clip;
        end
    end
endmodule

// File: rtl/led_cal_seq_ctrl.sv
// Calibrates N_CH LED channels (DC-offset search, then PGA-gain search) and then
// time-multiplexes them, publishing one settled ADC capture per dwell slot.
module led_cal_seq_ctrl
    import led_cal_seq_ctrl_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int ADC_W    = 8,
    parameter int DC_W     = 7,
    parameter int PGA_W    = 4,
    parameter int WIN      = 16,
    parameter int TGT_LO   = 120,
    parameter int TGT_HI   = 130,
    parameter int CLIP_LO  = 10,
    parameter int CLIP_HI  = 245,
    parameter int MAX_ITER = 127,
    parameter int DWELL    = 10,
    parameter int SETTLE   = 4
) (
    input logic                CLK,
    input logic                RST,
    led_cal_seq_ctrl_if.master bus
);
    localparam int CH_W   = $clog2(N_CH);
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam int SLOT_W = $clog2(DWELL);
    localparam int MID_W  = ADC_W + 1;

    state_t            state;
    logic [CH_W-1:0]   ch, ch_nxt;
    logic [ITER_W-1:0] iter;
    logic [SLOT_W-1:0] slot;
    logic [DC_W-1:0]   dc_mem  [N_CH];
    logic [PGA_W-1:0]  pga_mem [N_CH];
    logic              win_close, win_clip, win_clear;
    logic [ADC_W:0]    win_mid;
    logic              step_dn, step_up, dc_fail;

    led_cal_seq_ctrl_win_minmax #(
        .ADC_W(ADC_W), .WIN(WIN), .CLIP_LO(CLIP_LO), .CLIP_HI(CLIP_HI)
    ) u_win (
        .clk(CLK), .rst(RST), .clear(win_clear), .sample(bus.ADC), .vld(bus.ADC_Vld),
        .close(win_close), .clip(win_clip), .mid(win_mid)
    );

    // The window only accumulates while a search is running, so every phase starts fresh.
    always_comb begin
        win_clear = bus.Find_setting || !((state == DC_SRCH) || (state == PGA_SRCH));
        ch_nxt    = (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
        step_dn   = win_mid < MID_W'(TGT_LO);
        step_up   = win_mid > MID_W'(TGT_HI);
        dc_fail   = (step_dn && (bus.DC_Comp == '0)) || (step_up && (&bus.DC_Comp)) ||
                    ((step_dn || step_up) && (iter == ITER_W'(MAX_ITER)));
    end

    always_ff @(posedge CLK) begin
        if (RST) bus.CLK_Filter <= 1'b0;
        else     bus.CLK_Filter <= ~bus.CLK_Filter;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ch    <= '0;
            iter  <= '0;
            slot  <= '0;
            // NOTE: the settings table is a few flops with defined reset contents, so it is cleared like ordinary state rather than left to a RAM.
            for (int k = 0; k < N_CH; k++) begin
                dc_mem[k]  <= '0;
                pga_mem[k] <= '0;
            end
            bus.LED_EN        <= '0;
            bus.DC_Comp       <= '0;
            bus.PGA_Gain      <= '0;
            bus.ADC_Value     <= '0;
            bus.ADC_Value_Vld <= '0;
            bus.Cal_Done      <= 1'b0;
            bus.Cal_Fail      <= '0;
        end else begin
            bus.ADC_Value_Vld <= '0;
            if (bus.Find_setting) begin
                state        <= DC_SRCH;
                ch           <= '0;
                iter         <= '0;
                bus.DC_Comp  <= '0;
                bus.PGA_Gain <= '0;
                bus.Cal_Fail <= '0;
                bus.Cal_Done <= 1'b0;
                bus.LED_EN   <= N_CH'(one_hot(0));
            end else begin
                unique case (state)
                    IDLE: ;
                    DC_SRCH: if (win_close) begin
                        if (dc_fail) begin
                            bus.Cal_Fail[ch] <= 1'b1;
                            dc_mem[ch]       <= bus.DC_Comp;
                            bus.PGA_Gain     <= '0;
                            state            <= PGA_SRCH;
                        end else if (step_dn) begin
                            bus.DC_Comp <= bus.DC_Comp - 1'b1;
                            iter        <= iter + 1'b1;
                        end else if (step_up) begin
                            bus.DC_Comp <= bus.DC_Comp + 1'b1;
                            iter        <= iter + 1'b1;
                        end else begin
                            dc_mem[ch]   <= bus.DC_Comp;
                            bus.PGA_Gain <= '0;
                            state        <= PGA_SRCH;
                        end
                    end
                    PGA_SRCH: if (win_close) begin
                        if (win_clip) begin
                            pga_mem[ch] <= PGA_W'(clamp(int'(bus.PGA_Gain) - 1, 0, (1 << PGA_W) - 1));
                            state       <= NEXT_CH;
                        end else if (&bus.PGA_Gain) begin
                            pga_mem[ch] <= bus.PGA_Gain;
                            state       <= NEXT_CH;
                        end else begin
                            bus.PGA_Gain <= bus.PGA_Gain + 1'b1;
                        end
                    end
                    NEXT_CH: begin
                        ch         <= ch_nxt;
                        bus.LED_EN <= N_CH'(one_hot(int'(ch_nxt)));
                        if (ch == CH_W'(N_CH - 1)) begin
                            state        <= OPERATION;
                            slot         <= '0;
                            bus.DC_Comp  <= dc_mem[ch_nxt];
                            bus.PGA_Gain <= pga_mem[ch_nxt];
                            bus.Cal_Done <= 1'b1;
                        end else begin
                            state        <= DC_SRCH;
                            iter         <= '0;
                            bus.DC_Comp  <= '0;
                            bus.PGA_Gain <= '0;
                        end
                    end
                    OPERATION: begin
                        // Sampling the last cycle of the settle period makes the strobe appear at slot count SETTLE.
                        if (slot == SLOT_W'(SETTLE - 1)) begin
                            bus.ADC_Value[int'(ch)*ADC_W +: ADC_W] <= bus.ADC;
                            bus.ADC_Value_Vld[ch]                  <= 1'b1;
                        end
                        if (slot == SLOT_W'(DWELL - 1)) begin
                            slot         <= '0;
                            ch           <= ch_nxt;
                            bus.LED_EN   <= N_CH'(one_hot(int'(ch_nxt)));
                            bus.DC_Comp  <= dc_mem[ch_nxt];
                            bus.PGA_Gain <= pga_mem[ch_nxt];
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_cal_seq_ctrl.sv
// Randomized bench: a window-level calibration model generates each window's samples,
// predicts the search decisions, and predicts the OPERATION slot schedule.
`timescale 1ns/1ps
module tb_led_cal_seq_ctrl;
    localparam int N_CH = 2, ADC_W = 8, DC_W = 7, PGA_W = 4, WIN = 16;
    localparam int TGT_LO = 120, TGT_HI = 130, CLIP_LO = 10, CLIP_HI = 245;
    localparam int MAX_ITER = 127, DWELL = 10, SETTLE = 4;
    localparam int DC_MAX = (1 << DC_W) - 1, PGA_MAX = (1 << PGA_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_cal_seq_ctrl_if #(.N_CH(N_CH), .ADC_W(ADC_W), .DC_W(DC_W), .PGA_W(PGA_W)) bus ();

    led_cal_seq_ctrl #(
        .N_CH(N_CH), .ADC_W(ADC_W), .DC_W(DC_W), .PGA_W(PGA_W), .WIN(WIN),
        .TGT_LO(TGT_LO), .TGT_HI(TGT_HI), .CLIP_LO(CLIP_LO), .CLIP_HI(CLIP_HI),
        .MAX_ITER(MAX_ITER), .DWELL(DWELL), .SETTLE(SETTLE)
    ) dut (.CLK(clk), .RST(rst), .bus(bus));

    int checks = 0, failures = 0;

    // Reference state: stored settings, sticky fails, captured lanes, filter clock.
    int               m_dc [N_CH];
    int               m_pga[N_CH];
    logic [N_CH-1:0]  m_fail = '0;
    logic [ADC_W-1:0] m_lane[N_CH];
    logic             m_cf;
    int sc_mode[N_CH], sc_base[N_CH], sc_noise[N_CH], sc_k[N_CH];

    always @(posedge clk) m_cf <= rst ? 1'b0 : ~m_cf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; returns at the next falling edge with outputs settled.
    task automatic cyc(input logic vld, input int a, input logic find);
        bus.ADC_Vld      = vld;
        bus.ADC          = ADC_W'(a);
        bus.Find_setting = find;
        @(negedge clk);
        check("clk_filter", bus.CLK_Filter, m_cf);
    endtask

    function automatic int clamp8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic logic [N_CH*ADC_W-1:0] lanes();
        logic [N_CH*ADC_W-1:0] v;
        v = '0;
        for (int k = 0; k < N_CH; k++) v[k*ADC_W +: ADC_W] = m_lane[k];
        return v;
    endfunction

    function automatic int norm_sample();
        case ($urandom_range(0, 3))
            0:       return CLIP_LO;
            1:       return CLIP_HI;
            default: return $urandom_range(CLIP_LO, CLIP_HI);
        endcase
    endfunction

    function automatic int clip_sample();
        case ($urandom_range(0, 3))
            0:       return CLIP_LO - 1;
            1:       return CLIP_HI + 1;
            2:       return $urandom_range(0, CLIP_LO - 1);
            default: return $urandom_range(CLIP_HI + 1, 255);
        endcase
    endfunction

    task automatic set_sc(input int c, input int mode, input int base, input int noise, input int k);
        sc_mode[c] = mode; sc_base[c] = base; sc_noise[c] = noise; sc_k[c] = k;
    endtask

    // Drives one full window of WIN valid samples with random stalls; returns its statistics.
    task automatic run_window(input int c, input bit pga_phase, input int dc, input int pga,
                              output int mn, output int mx, output bit clp);
        int pos, s;
        pos = $urandom_range(0, WIN - 1);
        mn = 255; mx = 0; clp = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (!pga_phase)
                s = clamp8((sc_mode[c] == 0 ? sc_base[c] : sc_base[c] - dc) + $urandom_range(0, sc_noise[c]));
            else if (pga >= sc_k[c] && i == pos)
                s = clip_sample();
            else
                s = norm_sample();
            while ($urandom_range(0, 1) == 1) cyc(1'b0, $urandom_range(0, 255), 1'b0);
            cyc(1'b1, s, 1'b0);
            if (s < mn) mn = s;
            if (s > mx) mx = s;
            if (s < CLIP_LO || s > CLIP_HI) clp = 1'b1;
        end
        check("srch_done_low", bus.Cal_Done, 0);
        check("srch_led", bus.LED_EN, 1 << c);
    endtask

    task automatic start_cal();
        m_fail = '0;
        cyc(1'b0, $urandom_range(0, 255), 1'b1);
        check("start_led", bus.LED_EN, 1);
        check("start_dc", bus.DC_Comp, 0);
        check("start_pga", bus.PGA_Gain, 0);
        check("start_done", bus.Cal_Done, 0);
        check("start_fail", bus.Cal_Fail, 0);
        check("start_lanes_kept", bus.ADC_Value, lanes());
    endtask

    // Full calibration of all channels; with abort_win >= 0 it leaves a partial window
    // behind at that window number and returns so the caller can restart.
    task automatic calibrate(input int abort_win, output bit aborted);
        int win_cnt, dc, iter, pga, mn, mx, mid, nd;
        bit clp;
        aborted = 1'b0;
        win_cnt = 0;
        for (int c = 0; c < N_CH; c++) begin
            dc = 0; iter = 0; pga = 0;
            forever begin
                if (win_cnt == abort_win) begin
                    repeat (5) cyc(1'b1, 255, 1'b0);
                    aborted = 1'b1;
                    return;
                end
                win_cnt++;
                run_window(c, 1'b0, dc, 0, mn, mx, clp);
                mid = (mn + mx) / 2;
                if (mid >= TGT_LO && mid <= TGT_HI) break;
                nd = (mid < TGT_LO) ? dc - 1 : dc + 1;
                if (nd < 0 || nd > DC_MAX || iter == MAX_ITER) begin
                    m_fail[c] = 1'b1;
                    break;
                end
                dc = nd;
                iter++;
                check("dc_step", bus.DC_Comp, dc);
            end
            m_dc[c] = dc;
            check("dc_stored_hold", bus.DC_Comp, dc);
            check("pga_start", bus.PGA_Gain, 0);
            check("dc_fail_flag", bus.Cal_Fail, m_fail);
            forever begin
                if (win_cnt == abort_win) begin
                    repeat (5) cyc(1'b1, 255, 1'b0);
                    aborted = 1'b1;
                    return;
                end
                win_cnt++;
                run_window(c, 1'b1, dc, pga, mn, mx, clp);
                if (clp) begin
                    m_pga[c] = (pga == 0) ? 0 : pga - 1;
                    break;
                end
                if (pga == PGA_MAX) begin
                    m_pga[c] = PGA_MAX;
                    break;
                end
                pga++;
                check("pga_step", bus.PGA_Gain, pga);
                check("pga_dc_hold", bus.DC_Comp, dc);
            end
            check("pga_fail_flag", bus.Cal_Fail, m_fail);
            cyc(1'b0, $urandom_range(0, 255), 1'b0);
            if (c < N_CH - 1) begin
                check("next_led", bus.LED_EN, 1 << (c + 1));
                check("next_dc", bus.DC_Comp, 0);
                check("next_pga", bus.PGA_Gain, 0);
                check("next_done", bus.Cal_Done, 0);
            end
        end
    endtask

    // Called at the first cycle of OPERATION; checks ncyc cycles of the slot schedule.
    task automatic op_run(input int ncyc);
        int prev_adc, a, cc, ch;
        prev_adc = 0;
        for (int k = 0; k < ncyc; k++) begin
            cc = k % DWELL;
            ch = (k / DWELL) % N_CH;
            check("op_done", bus.Cal_Done, 1);
            check("op_led", bus.LED_EN, 1 << ch);
            check("op_dc", bus.DC_Comp, m_dc[ch]);
            check("op_pga", bus.PGA_Gain, m_pga[ch]);
            check("op_fail", bus.Cal_Fail, m_fail);
            if (cc == SETTLE) begin
                m_lane[ch] = ADC_W'(prev_adc);
                check("op_vld", bus.ADC_Value_Vld, 1 << ch);
            end else begin
                check("op_vld_idle", bus.ADC_Value_Vld, 0);
            end
            check("op_lanes", bus.ADC_Value, lanes());
            a = ($urandom_range(0, 1) == 1) ? 'h40 + ((k + 1) / DWELL) % N_CH : $urandom_range(0, 255);
            prev_adc = a;
            cyc(1'(($urandom_range(0, 1))), a, 1'b0);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_led"}, bus.LED_EN, 0);
        check({tag, "_dc"}, bus.DC_Comp, 0);
        check({tag, "_pga"}, bus.PGA_Gain, 0);
        check({tag, "_cf"}, bus.CLK_Filter, 0);
        check({tag, "_lanes"}, bus.ADC_Value, 0);
        check({tag, "_vld"}, bus.ADC_Value_Vld, 0);
        check({tag, "_done"}, bus.Cal_Done, 0);
        check({tag, "_fail"}, bus.Cal_Fail, 0);
    endtask

    initial begin
        bit ab;
        for (int k = 0; k < N_CH; k++) m_lane[k] = '0;
        bus.ADC = '0; bus.ADC_Vld = 1'b0; bus.Find_setting = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (6) cyc(1'b1, 125, 1'b0);
        check("idle_led", bus.LED_EN, 0);
        check("idle_done", bus.Cal_Done, 0);

        // Run 1: ramp 150-dc settles at dc=20; ch1 pinned at 200 walks to 127 and fails.
        set_sc(0, 1, 150, 0, 16);
        set_sc(1, 0, 200, 0, 0);
        start_cal();
        calibrate(-1, ab);
        op_run(4 * DWELL + 7);

        // Run 2: random scenarios, entered by a restart from OPERATION.
        for (int c = 0; c < N_CH; c++)
            set_sc(c, $urandom_range(0, 1), $urandom_range(100, 190), $urandom_range(0, 4), $urandom_range(0, 16));
        start_cal();
        calibrate(-1, ab);
        op_run(3 * DWELL + 2);

        // Run 3: centred ch0, aborted mid-window during its PGA search, then rerun.
        set_sc(0, 0, 125, 0, 16);
        set_sc(1, 1, $urandom_range(120, 170), $urandom_range(0, 3), $urandom_range(1, 15));
        start_cal();
        calibrate(2, ab);
        check("abort_taken", ab, 1);
        start_cal();
        calibrate(-1, ab);
        op_run(2 * N_CH * DWELL + 3);

        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N_CH; k++) m_lane[k] = '0;
        check_reset("rst_pulse");
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
